mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage: 256x64 data memory with one-cycle load stall,
// direct ALU write-back, saturating store counter and a combinational debug read port.
module mem_wb_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [78:0] Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
   input  logic        in_valid,
   output logic        stall,
   output logic        wb_en,
   output logic [3:0]  wb_reg,
   output logic [63:0] wb_value,
   input  logic [7:0]  dbg_addr,
   output logic [63:0] dbg_data,
   output logic [15:0] store_count
);

   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  in_addr;
   logic [63:0] in_value;
   logic        in_is_write, in_is_mem_write, in_is_load;
   logic [3:0]  in_dst;

   logic        do_store, do_load, do_alu;
   logic [7:0]  load_addr_reg;
   logic [3:0]  load_dst_reg;
   logic        wb_en_reg;
   logic [3:0]  wb_dst_reg;
   logic [63:0] wb_value_reg;
   logic [15:0] store_count_reg;

   logic [63:0] mem [0:255];

   assign in_addr         = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[7:0];
   assign in_value        = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[71:8];
   assign in_is_write     = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[72];
   assign in_is_mem_write = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[73];
   assign in_is_load      = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[74];
   assign in_dst          = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[78:75];

   // Decode: store beats load beats ALU write; bundles are ignored while a load is pending.
   always_comb begin
      state_next = state_reg;
      do_store   = 1'b0;
      do_load    = 1'b0;
      do_alu     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (in_is_mem_write) begin
                  do_store = 1'b1;
               end else if (in_is_load) begin
                  do_load    = 1'b1;
                  state_next = LOAD_WAIT;
               end else if (in_is_write) begin
                  do_alu = 1'b1;
               end
            end
         end
         LOAD_WAIT: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         load_addr_reg   <= 8'd0;
         load_dst_reg    <= 4'd0;
         wb_en_reg       <= 1'b0;
         wb_dst_reg      <= 4'd0;
         wb_value_reg    <= 64'd0;
         store_count_reg <= 16'd0;
      end else begin
         state_reg <= state_next;
         wb_en_reg <= do_alu || (state_reg == LOAD_WAIT);
         if (do_load) begin
            load_addr_reg <= in_addr;
            load_dst_reg  <= in_dst;
         end
         if (do_alu) begin
            wb_dst_reg   <= in_dst;
            wb_value_reg <= in_value;
         end else if (state_reg == LOAD_WAIT) begin
            wb_dst_reg   <= load_dst_reg;
            wb_value_reg <= mem[load_addr_reg];
         end
         if (do_store && (store_count_reg != 16'hFFFF)) begin
            store_count_reg <= store_count_reg + 16'd1;
         end
      end
   end

   // Memory contents survive reset; writes are still blocked while reset is held.
   always_ff @(posedge clk) begin
      if (do_store && rst_n) begin
         mem[in_addr] <= in_value;
      end
   end

   assign stall       = (state_reg == LOAD_WAIT);
   assign wb_en       = wb_en_reg;
   assign wb_reg      = wb_dst_reg;
   assign wb_value    = wb_value_reg;
   assign store_count = store_count_reg;
   assign dbg_data    = mem[dbg_addr];

endmodule
